// File: rtl/spi_slave_transmitter_pkg.sv
//------------------------------------------------------------------------------
// spi_slave_transmitter_pkg
// Shared types for the SPI slave transmitter.
//   bus_ev_t    : polarity-normalised view of the synchronised ss/sclk pins
//   frame_act_t : what the transmitter does with its counter/miso this cycle
//   SYNC_STAGES : depth of the pin synchroniser (metastability filter)
//------------------------------------------------------------------------------
`timescale 1ns / 1ps
package spi_slave_transmitter_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    // Pin events after synchronisation and polarity normalisation.
    typedef struct packed {
        logic ss_active;  // slave select currently at its active level
        logic ss_assert;  // ss has just become active (frame start)
        logic lead;       // sclk has just left its idle level
        logic trail;      // sclk has just returned to its idle level
    } bus_ev_t;

    // Per-cycle action on the counter and miso register, in priority order.
    typedef enum logic [1:0] {
        ACT_START = 2'd0,  // frame start: rewind to the first bit
        ACT_IDLE  = 2'd1,  // ss inactive: miso low, counter cleared
        ACT_SHIFT = 2'd2,  // shift edge inside a frame: present next bit
        ACT_HOLD  = 2'd3   // inside a frame, nothing to do
    } frame_act_t;

endpackage

// File: rtl/spi_pin_sync.sv
//------------------------------------------------------------------------------
// spi_pin_sync
// Synchroniser plus edge detector for one asynchronous input pin.
// The pin passes SYNC_STAGES flops, then one history flop; an edge is
// reported for exactly one clock when the synchronised value differs from
// the history flop.
// Ports:
//   clock   in   system clock
//   reset_n in   asynchronous active-low reset (flops return to IDLE)
//   pin_i   in   raw asynchronous pin
//   level_o out  synchronised pin level
//   rise_o  out  one-cycle pulse on a 0->1 transition
//   fall_o  out  one-cycle pulse on a 1->0 transition
//------------------------------------------------------------------------------
`timescale 1ns / 1ps
module spi_pin_sync
    import spi_slave_transmitter_pkg::*;
#(
    parameter logic IDLE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value from before this edge; blocking here would
    // collapse the synchroniser into a single stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE}};
            hist_q <= IDLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_transmitter.sv
//------------------------------------------------------------------------------
// spi_slave_transmitter
// SPI slave-side serial transmitter. A parallel word is latched (on load, or
// on ss assertion) and presented bit by bit on miso as an external master
// toggles sclk while ss is active. ss/sclk are oversampled by the system
// clock; miso moves 3 clocks after the pin edge that causes it.
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   ss       in   slave select from master (asynchronous)
//   sclk     in   serial clock from master (asynchronous)
//   load     in   latch data while idle (level, sampled each clock)
//   data     in   parallel word to transmit [bitcount-1:0]
//   miso     out  serial data out (0 whenever ss is inactive)
//------------------------------------------------------------------------------
`timescale 1ns / 1ps
module spi_slave_transmitter
    import spi_slave_transmitter_pkg::*;
#(
    parameter int unsigned bitcount       = 8,
    parameter bit          ss_polarity    = 1'b0,
    parameter bit          sclk_polarity  = 1'b1,
    parameter bit          sclk_phase     = 1'b1,
    parameter bit          msb_first      = 1'b1,
    parameter bit          use_load_input = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ss,
    input  logic                sclk,
    input  logic                load,
    input  logic [bitcount-1:0] data,
    output logic                miso
);

    // One spare count value so "counter + 1" never wraps at saturation.
    localparam int unsigned CW = $clog2(bitcount + 2);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;

    spi_pin_sync #(.IDLE(!ss_polarity)) u_ss_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .pin_i   (ss),
        .level_o (ss_lvl),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_pin_sync #(.IDLE(sclk_polarity)) u_sclk_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .pin_i   (sclk),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // Polarity normalisation: after the XOR, ss is active-high and sclk idles
    // low, so any edge landing on the new level tells us which edge it was.
    bus_ev_t ev;
    logic    ss_norm, sclk_norm;

    assign ss_norm      = ss_lvl ^ !ss_polarity;
    assign sclk_norm    = sclk_lvl ^ sclk_polarity;
    assign ev.ss_active = ss_norm;
    assign ev.ss_assert = (ss_rise | ss_fall) & ss_norm;
    assign ev.lead      = (sclk_rise | sclk_fall) & sclk_norm;
    assign ev.trail     = (sclk_rise | sclk_fall) & !sclk_norm;

    logic [bitcount-1:0] word_q, word_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                miso_q, miso_d;
    logic                shift_edge;
    logic                load_ok;
    frame_act_t          act;

    // Bit number idx of the frame, honouring the transmit order; positions
    // past the end of the word read as 0.
    function automatic logic bit_at(input logic [bitcount-1:0] w,
                                    input logic [CW-1:0]       idx);
        logic [bitcount-1:0] shifted;
        if (idx >= CW'(bitcount)) begin
            return 1'b0;
        end
        shifted = msb_first ? (w >> (CW'(bitcount - 1) - idx)) : (w >> idx);
        return shifted[0];
    endfunction

    assign shift_edge = sclk_phase ? ev.lead : ev.trail;
    assign load_ok    = use_load_input && load && (cnt_q == '0);

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        miso_d = miso_q;

        if (use_load_input ? load_ok : ev.ss_assert) begin
            word_d = data;
        end

        if (ev.ss_assert) begin
            act = ACT_START;
        end else if (!ev.ss_active) begin
            act = ACT_IDLE;
        end else if (shift_edge) begin
            act = ACT_SHIFT;
        end else begin
            act = ACT_HOLD;
        end

        unique case (act)
            ACT_START: begin
                // word_d, so a load in the same cycle supplies the first bit.
                cnt_d  = '0;
                miso_d = bit_at(word_d, '0);
            end
            ACT_IDLE: begin
                cnt_d  = '0;
                miso_d = 1'b0;
            end
            ACT_SHIFT: begin
                cnt_d  = (cnt_q == CW'(bitcount)) ? cnt_q : cnt_q + CW'(1);
                // CPHA=1: leading edge k presents bit k-1 (bit 0 already out).
                // CPHA=0: trailing edge k presents bit k.
                miso_d = bit_at(word_d, sclk_phase ? cnt_q : cnt_q + CW'(1));
            end
            ACT_HOLD: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            miso_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            miso_q <= miso_d;
        end
    end

    assign miso = miso_q;

endmodule

// File: tb/tb_spi_slave_transmitter.sv
//------------------------------------------------------------------------------
// tb_spi_slave_transmitter
// Three transmitters share clock, reset, load and data:
//   u_a : defaults (CPOL=1, CPHA=1, ss active-low, msb first)
//   u_b : as u_a but lsb first
//   u_c : CPHA=0, CPOL=0, ss active-high, msb first
// A master model drives one normalised ss/sclk pair, mapped onto each
// instance's pin polarity, and samples miso on the edge its mode dictates.
// Expected bits come from the loaded word and the transmit order; literal
// byte checks pin the expected sequences.
//------------------------------------------------------------------------------
`timescale 1ns / 1ps
module tb_spi_slave_transmitter;

    localparam int HALF = 5;  // master half period in system clocks

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       load    = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       m_ss    = 1'b0;  // 1 = master selects the slave
    logic       m_sck   = 1'b0;  // 1 = sclk away from its idle level
    logic       ss_ab, sclk_ab, ss_c, sclk_c;
    logic       miso_a, miso_b, miso_c;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_word = 8'h00;
    int         idle_cycles = 0;

    always #1 clock = ~clock;

    assign ss_ab   = ~m_ss;
    assign sclk_ab = ~m_sck;
    assign ss_c    = m_ss;
    assign sclk_c  = m_sck;

    spi_slave_transmitter u_a (
        .clock(clock), .reset_n(reset_n), .ss(ss_ab), .sclk(sclk_ab),
        .load(load), .data(data), .miso(miso_a)
    );

    spi_slave_transmitter #(.msb_first(1'b0)) u_b (
        .clock(clock), .reset_n(reset_n), .ss(ss_ab), .sclk(sclk_ab),
        .load(load), .data(data), .miso(miso_b)
    );

    spi_slave_transmitter #(.sclk_phase(1'b0), .sclk_polarity(1'b0),
                            .ss_polarity(1'b1)) u_c (
        .clock(clock), .reset_n(reset_n), .ss(ss_c), .sclk(sclk_c),
        .load(load), .data(data), .miso(miso_c)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Bit i of a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input logic msb,
                                     input int i);
        return msb ? w[7 - i] : w[i];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Whenever the master has kept ss released for a while, every miso is 0.
    always @(negedge clock) begin
        if (m_ss || !reset_n) begin
            idle_cycles = 0;
        end else begin
            idle_cycles++;
        end
        if (idle_cycles > 5) begin
            check("idle_miso_a", miso_a, 1'b0);
            check("idle_miso_b", miso_b, 1'b0);
            check("idle_miso_c", miso_c, 1'b0);
        end
    end

    task automatic load_word(input logic [7:0] w);
        data = w;
        load = 1'b1;
        wait_clk(2);
        load = 1'b0;
        wait_clk(2);
        model_word = w;
    endtask

    // One master frame of nclk sclk cycles. After the trailing edge of bit
    // mid_at, data changes to mid_data and load pulses if mid_load is set.
    // rx* collect the sampled bits, first bit ending up most significant.
    task automatic frame(input int nclk, input int mid_at,
                         input logic [7:0] mid_data, input logic mid_load,
                         output logic [7:0] rxa, output logic [7:0] rxb,
                         output logic [7:0] rxc);
        rxa = '0;
        rxb = '0;
        rxc = '0;
        m_ss = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < nclk; i++) begin
            rxc = {rxc[6:0], miso_c};
            check($sformatf("c_bit%0d", i), miso_c, exp_bit(model_word, 1'b1, i));
            m_sck = 1'b1;
            wait_clk(HALF);
            rxa = {rxa[6:0], miso_a};
            rxb = {rxb[6:0], miso_b};
            check($sformatf("a_bit%0d", i), miso_a, exp_bit(model_word, 1'b1, i));
            check($sformatf("b_bit%0d", i), miso_b, exp_bit(model_word, 1'b0, i));
            m_sck = 1'b0;
            if (i == mid_at) begin
                wait_clk(1);
                data = mid_data;
                load = mid_load;
                wait_clk(2);
                load = 1'b0;
                wait_clk(HALF - 3);
            end else begin
                wait_clk(HALF);
            end
        end
        m_ss = 1'b0;
        wait_clk(2 * HALF);
    endtask

    logic [7:0] ra, rb, rc;

    initial begin
        // Reset state.
        wait_clk(3);
        check("reset_miso_a", miso_a, 1'b0);
        check("reset_miso_b", miso_b, 1'b0);
        check("reset_miso_c", miso_c, 1'b0);
        reset_n = 1'b1;
        wait_clk(8);

        // Frame with no load: the reset word (all zero) goes out.
        frame(8, -1, 8'h00, 1'b0, ra, rb, rc);
        check("noload_a", ra, 8'h00);

        // 0x3b; data changes mid-frame without load and must not matter.
        load_word(8'h3b);
        frame(8, 2, 8'h8e, 1'b0, ra, rb, rc);
        check("w3b_a", ra, 8'h3b);
        check("w3b_b_lsb", rb, 8'hdc);
        check("w3b_c_cpha0", rc, 8'h3b);

        // Second load with 0x8e.
        load_word(8'h8e);
        frame(8, -1, 8'h00, 1'b0, ra, rb, rc);
        check("w8e_a", ra, 8'h8e);
        check("w8e_b_lsb", rb, 8'h71);
        check("w8e_c_cpha0", rc, 8'h8e);

        // Load of 0xff mid-frame is ignored.
        load_word(8'h3b);
        frame(8, 2, 8'hff, 1'b1, ra, rb, rc);
        check("midload_a", ra, 8'h3b);
        check("midload_b", rb, 8'hdc);
        check("midload_c", rc, 8'h3b);

        // Abort after 3 bits, then a full frame restarts at bit 0.
        frame(3, -1, 8'h00, 1'b0, ra, rb, rc);
        check("abort_a", ra, 8'h01);
        check("abort_c", rc, 8'h01);
        frame(8, -1, 8'h00, 1'b0, ra, rb, rc);
        check("restart_a", ra, 8'h3b);
        check("restart_b", rb, 8'hdc);
        check("restart_c", rc, 8'h3b);

        // Reset in the middle of a frame of ones.
        load_word(8'hff);
        m_ss = 1'b1;
        wait_clk(HALF);
        m_sck = 1'b1;
        wait_clk(HALF);
        m_sck = 1'b0;
        wait_clk(HALF);
        check("pre_reset_a", miso_a, 1'b1);
        check("pre_reset_c", miso_c, 1'b1);
        reset_n = 1'b0;
        #0.5;
        check("rst_mid_a", miso_a, 1'b0);
        check("rst_mid_b", miso_b, 1'b0);
        check("rst_mid_c", miso_c, 1'b0);
        m_ss  = 1'b0;
        model_word = 8'h00;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(10);

        // After reset: word cleared, counter starts from bit 0 again.
        frame(8, -1, 8'h00, 1'b0, ra, rb, rc);
        check("post_reset_a", ra, 8'h00);
        check("post_reset_c", rc, 8'h00);
        load_word(8'h3b);
        frame(8, -1, 8'h00, 1'b0, ra, rb, rc);
        check("post_reset_w3b_a", ra, 8'h3b);
        check("post_reset_w3b_b", rb, 8'hdc);
        check("post_reset_w3b_c", rc, 8'h3b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
